// File: rtl/pcs_tx_oset_scheduler.sv
// pcs_tx_oset_scheduler
//   Chooses the octet handed to the 8b/10b encoder on every GTX_CLK. It
//   produces idle (/I1/, /I2/), configuration (/C1/, /C2/) and packet
//   (/S/, data, /V/, /T/, /R/) code groups. Every ordered set starts on
//   an even slot.
//
// Ports
//   GTX_CLK     transmit clock, one code group per cycle
//   RESET       asynchronous active-high reset
//   xmit        00 IDLE, 01 DATA, 10 CONFIGURATION, 11 treated as IDLE
//   TX_EN       GMII transmit enable
//   TX_ER       GMII transmit error
//   TXD         GMII transmit data
//   tx_rd       encoder running disparity before the current group (1 = RD+)
//   tx_cfg_reg  auto-negotiation configuration word
//   tx_o_set    octet to the encoder
//   tx_o_set_k  1 when tx_o_set is a K code group
//   enc_tx_en   1 on /S/, data and /V/ slots
//   tx_even     1 when the current slot is even
//   tx_busy     1 from /S/ through the last /R/
//   pkt_drop    one-cycle pulse when a packet start is refused
//   pkt_trunc   one-cycle pulse with a /T/ forced by an xmit change

module pcs_tx_oset_scheduler #(
  parameter int MIN_IDLE_SETS = 1
) (
  input  logic        GTX_CLK,
  input  logic        RESET,
  input  logic [1:0]  xmit,
  input  logic        TX_EN,
  input  logic        TX_ER,
  input  logic [7:0]  TXD,
  input  logic        tx_rd,
  input  logic [15:0] tx_cfg_reg,
  output logic [7:0]  tx_o_set,
  output logic        tx_o_set_k,
  output logic        enc_tx_en,
  output logic        tx_even,
  output logic        tx_busy,
  output logic        pkt_drop,
  output logic        pkt_trunc
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] SYM_S = 8'hFB;
  localparam logic [7:0] SYM_T = 8'hFD;
  localparam logic [7:0] SYM_R = 8'hF7;
  localparam logic [7:0] SYM_V = 8'hFE;
  localparam logic [2:0] MIN_SETS = 3'(MIN_IDLE_SETS);

  // The state names the kind of code group currently on tx_o_set.
  // PKT shows /S/, data, /V/ and finally /T/ (eop set while /T/ is shown).
  typedef enum logic [3:0] {
    IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, PKT, EPD_R1, EPD_R2
  } state_t;

  typedef enum logic [1:0] {MODE_IDLE, MODE_DATA, MODE_CFG} mode_t;

  state_t      state;
  mode_t       mode;
  mode_t       xmit_mode;
  logic [1:0]  idle_cnt;
  logic        cfg_c2;
  logic [15:0] cfg_hold;
  logic        pipe_en;
  logic        pipe_er;
  logic [7:0]  pipe_d;
  logic        lat2;
  logic        sop_pend;
  logic        eop;
  logic [2:0]  cnt_ext;
  logic        rise;
  logic        sop_even;
  logic        sop_odd;
  logic        start_set;
  logic        sel_en;
  logic        sel_er;
  logic [7:0]  sel_d;

  // Decode xmit into a mode; the reserved code 11 behaves like IDLE.
  always_comb begin
    case (xmit)
      2'b01:   xmit_mode = MODE_DATA;
      2'b10:   xmit_mode = MODE_CFG;
      default: xmit_mode = MODE_IDLE;
    endcase
  end

  // Packet start decisions. A rising TX_EN while the idle D octet is shown
  // means the next slot is even, so /S/ can replace the first byte directly.
  // A rise while the K is shown means the idle set must finish first, so
  // the idle D goes out now and /S/ follows from the one-byte pipeline;
  // the idle set being completed by that D already counts.
  assign cnt_ext  = {1'b0, idle_cnt};
  assign rise     = TX_EN & ~pipe_en;
  assign sop_even = rise && (state == IDLE_D) && !sop_pend &&
                    (mode == MODE_DATA) && (xmit_mode == MODE_DATA) &&
                    (cnt_ext >= MIN_SETS);
  assign sop_odd  = rise && (state == IDLE_K) && (mode == MODE_DATA) &&
                    ((cnt_ext + 3'd1) >= MIN_SETS);

  // A new ordered set begins on the next (even) slot whenever the current
  // odd slot closes a set and no packet is taking over. After /T/ on an
  // even slot the single /R/ is odd, so EPD_R1 can close the set itself.
  assign start_set = (state == IDLE_D && !sop_pend && !sop_even) ||
                     (state == CFG_HI) ||
                     (state == EPD_R1 && !tx_even) ||
                     (state == EPD_R2);

  // The packet byte path is either the live GMII byte or the previous one,
  // chosen at /S/ and held until /T/.
  assign sel_en = lat2 ? pipe_en : TX_EN;
  assign sel_er = lat2 ? pipe_er : TX_ER;
  assign sel_d  = lat2 ? pipe_d  : TXD;

  // Single registered FSM. Every output is a flop so the encoder sees a
  // clean octet, K flag and slot parity at the start of each cycle.
  always_ff @(posedge GTX_CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE_K;
      mode       <= MODE_IDLE;
      idle_cnt   <= 2'd0;
      cfg_c2     <= 1'b0;
      cfg_hold   <= 16'h0000;
      pipe_en    <= 1'b0;
      pipe_er    <= 1'b0;
      pipe_d     <= 8'h00;
      lat2       <= 1'b0;
      sop_pend   <= 1'b0;
      eop        <= 1'b0;
      tx_o_set   <= K28_5;
      tx_o_set_k <= 1'b1;
      enc_tx_en  <= 1'b0;
      tx_even    <= 1'b1;
      tx_busy    <= 1'b0;
      pkt_drop   <= 1'b0;
      pkt_trunc  <= 1'b0;
    end else begin
      tx_even   <= ~tx_even;
      pipe_en   <= TX_EN;
      pipe_er   <= TX_ER;
      pipe_d    <= TXD;
      pkt_drop  <= rise & ~sop_even & ~sop_odd;
      pkt_trunc <= 1'b0;
      enc_tx_en <= 1'b0;
      tx_busy   <= 1'b0;

      if (start_set) begin
        mode       <= xmit_mode;
        tx_o_set   <= K28_5;
        tx_o_set_k <= 1'b1;
        if (xmit_mode == MODE_CFG) begin
          state <= CFG_K;
          if (mode != MODE_CFG) begin
            cfg_c2 <= 1'b0;
          end
        end else begin
          state <= IDLE_K;
        end
      end else begin
        case (state)
          IDLE_K: begin
            tx_o_set   <= tx_rd ? D5_6 : D16_2;
            tx_o_set_k <= 1'b0;
            state      <= IDLE_D;
            sop_pend   <= sop_odd;
            if (cnt_ext < MIN_SETS) begin
              idle_cnt <= idle_cnt + 2'd1;
            end
          end
          IDLE_D: begin
            tx_o_set   <= SYM_S;
            tx_o_set_k <= 1'b1;
            enc_tx_en  <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= PKT;
            eop        <= 1'b0;
            idle_cnt   <= 2'd0;
            lat2       <= sop_pend;
            sop_pend   <= 1'b0;
          end
          CFG_K: begin
            cfg_hold   <= tx_cfg_reg;
            tx_o_set   <= cfg_c2 ? D2_2 : D21_5;
            tx_o_set_k <= 1'b0;
            state      <= CFG_D;
          end
          CFG_D: begin
            tx_o_set   <= cfg_hold[7:0];
            tx_o_set_k <= 1'b0;
            state      <= CFG_LO;
          end
          CFG_LO: begin
            tx_o_set   <= cfg_hold[15:8];
            tx_o_set_k <= 1'b0;
            state      <= CFG_HI;
            cfg_c2     <= ~cfg_c2;
          end
          PKT: begin
            tx_busy <= 1'b1;
            if (eop) begin
              tx_o_set   <= SYM_R;
              tx_o_set_k <= 1'b1;
              state      <= EPD_R1;
            end else if (!sel_en || xmit_mode != MODE_DATA) begin
              tx_o_set   <= SYM_T;
              tx_o_set_k <= 1'b1;
              eop        <= 1'b1;
              pkt_trunc  <= sel_en;
            end else if (sel_er) begin
              tx_o_set   <= SYM_V;
              tx_o_set_k <= 1'b1;
              enc_tx_en  <= 1'b1;
            end else begin
              tx_o_set   <= sel_d;
              tx_o_set_k <= 1'b0;
              enc_tx_en  <= 1'b1;
            end
          end
          EPD_R1: begin
            tx_o_set   <= SYM_R;
            tx_o_set_k <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= EPD_R2;
          end
          default: begin
            state <= IDLE_K;
          end
        endcase
      end
    end
  end

endmodule
